// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one row low at a time, debounces every key over
// several full scans and reports press/release events over a valid/ready handshake.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int NK = ROWS * COLS,
  localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] keypad_row,
  input  logic [COLS-1:0] keypad_column,
  output logic [NK-1:0]   keys,
  output logic            any_key,
  output logic            event_valid,
  input  logic            event_ready,
  output logic [KW-1:0]   event_code,
  output logic            event_pressed
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SETTLE, SAMPLE, EMIT, NEXT} state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] meta_q, sync_q;
  logic [SW-1:0]   settle_q, settle_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [ROWS-1:0] row_drv_q, row_drv_d;
  logic [NK-1:0]   keys_q, keys_d;
  logic [DW-1:0]   cnt_q [NK];
  logic [DW-1:0]   cnt_d [NK];
  logic [COLS-1:0] flip_q, flip_d;
  logic            any_q, any_d;
  logic            ev_vld_q, ev_vld_d;
  logic [KW-1:0]   ev_code_q, ev_code_d;
  logic            ev_pr_q, ev_pr_d;
  logic [COLS-1:0] sample;

  // Columns are active-low; internally 1 means "pressed".
  assign sample = ~sync_q;

  function automatic logic [KW-1:0] key_index(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return KW'(32'(r) * COLS + 32'(c));
  endfunction

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    row_d     = row_q;
    col_d     = col_q;
    row_drv_d = row_drv_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    flip_d    = flip_q;
    ev_vld_d  = ev_vld_q;
    ev_code_d = ev_code_q;
    ev_pr_d   = ev_pr_q;

    case (state_q)
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
        else                                    settle_d = settle_q + 1'b1;
      end
      SAMPLE: begin
        flip_d = '0;
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (row_q == RW'(r)) begin
              if (sample[c] == keys_q[r*COLS+c]) begin
                cnt_d[r*COLS+c] = '0;
              end else if (cnt_q[r*COLS+c] == DW'(DEBOUNCE_SCANS - 1)) begin
                keys_d[r*COLS+c] = ~keys_q[r*COLS+c];
                cnt_d[r*COLS+c]  = '0;
                flip_d[c]        = 1'b1;
              end else begin
                cnt_d[r*COLS+c] = cnt_q[r*COLS+c] + 1'b1;
              end
            end
          end
        end
        // Column 0's event is presented on the first EMIT cycle.
        col_d     = '0;
        state_d   = EMIT;
        ev_vld_d  = flip_d[0];
        ev_code_d = key_index(row_q, '0);
        ev_pr_d   = keys_d[ev_code_d];
      end
      EMIT: begin
        if (!ev_vld_q || event_ready) begin
          if (col_q == CW'(COLS - 1)) begin
            state_d  = NEXT;
            ev_vld_d = 1'b0;
          end else begin
            col_d     = col_q + 1'b1;
            ev_vld_d  = flip_q[col_d];
            ev_code_d = key_index(row_q, col_d);
            ev_pr_d   = keys_q[ev_code_d];
          end
        end
      end
      NEXT: begin
        row_d     = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        row_drv_d = ~({{(ROWS-1){1'b0}}, 1'b1} << row_d);
        settle_d  = '0;
        col_d     = '0;
        state_d   = SETTLE;
      end
      default: state_d = SETTLE;
    endcase

    any_d = |keys_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SETTLE;
      meta_q    <= '0;
      sync_q    <= '0;
      settle_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_drv_q <= {{(ROWS-1){1'b1}}, 1'b0};
      keys_q    <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
      flip_q    <= '0;
      any_q     <= 1'b0;
      ev_vld_q  <= 1'b0;
      ev_code_q <= '0;
      ev_pr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= keypad_column;
      sync_q    <= meta_q;
      settle_q  <= settle_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_drv_q <= row_drv_d;
      keys_q    <= keys_d;
      cnt_q     <= cnt_d;
      flip_q    <= flip_d;
      any_q     <= any_d;
      ev_vld_q  <= ev_vld_d;
      ev_code_q <= ev_code_d;
      ev_pr_q   <= ev_pr_d;
    end
  end

  assign keypad_row    = row_drv_q;
  assign keys          = keys_q;
  assign any_key       = any_q;
  assign event_valid   = ev_vld_q;
  assign event_code    = ev_code_q;
  assign event_pressed = ev_pr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key matrix model drives the columns and a
// scan-level debounce model predicts the key bitmap and the event stream.
module tb_keypad_scanner;
  localparam int DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  krow, kcol;
  logic [15:0] keys;
  logic        any_key, ev_vld, ev_pr;
  logic        ev_rdy = 1'b1;
  logic [3:0]  ev_code;
  logic [15:0] phys = '0;

  logic        s_rst = 1'b1;
  logic [1:0]  s_row;
  logic [2:0]  s_col;
  logic [5:0]  s_keys;
  logic        s_any, s_vld, s_pr;
  logic        s_rdy = 1'b1;
  logic [2:0]  s_code;
  logic [5:0]  s_phys = '0;

  keypad_scanner #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(16), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(rst), .keypad_row(krow), .keypad_column(kcol), .keys(keys),
    .any_key(any_key), .event_valid(ev_vld), .event_ready(ev_rdy),
    .event_code(ev_code), .event_pressed(ev_pr));

  keypad_scanner #(.ROWS(2), .COLS(3), .SETTLE_CYCLES(5), .DEBOUNCE_SCANS(1)) dut_s (
    .clk(clk), .reset(s_rst), .keypad_row(s_row), .keypad_column(s_col), .keys(s_keys),
    .any_key(s_any), .event_valid(s_vld), .event_ready(s_rdy),
    .event_code(s_code), .event_pressed(s_pr));

  // Switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kcol = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!krow[r] && phys[r*4+c]) kcol[c] = 1'b0;
    s_col = '1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 2; r++)
        if (!s_row[r] && s_phys[r*3+c]) s_col[c] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
  logic [4:0]  got_q[$];
  logic [4:0]  exp_q[$];
  logic [3:0]  s_got_q[$];
  logic [15:0] m_stable = '0;
  int          m_cnt[16];

  always @(negedge clk) begin
    case (rdy_mode)
      0:       ev_rdy = 1'b1;
      1:       ev_rdy = 1'($urandom_range(0, 1));
      default: ev_rdy = 1'b0;
    endcase
    if (ev_vld && ev_rdy) got_q.push_back({ev_code, ev_pr});
    if (s_vld && s_rdy)   s_got_q.push_back({s_code, s_pr});
  end

  // One full scan sees a constant key pattern: each key either agrees and
  // resets its count, or disagrees and flips after DEB consecutive scans.
  task automatic model_scan(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == m_stable[k]) m_cnt[k] = 0;
      else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEB) begin
          m_stable[k] = ~m_stable[k];
          m_cnt[k]    = 0;
          exp_q.push_back({4'(k), m_stable[k]});
        end
      end
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_boundary();
    logic [3:0] prev;
    bit ok;
    prev = krow;
    ok   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (krow == 4'b1110 && prev != 4'b1110) begin ok = 1'b1; break; end
      prev = krow;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL scan_boundary_timeout row=%b want a return to 1110", krow);
    end
  endtask

  // Called at a scan boundary; returns at the next one.
  task automatic do_scan(input logic [15:0] pat);
    phys = pat;
    model_scan(pat);
    wait_boundary();
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    logic [3:0] walk[4];
    int n;
    walk = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (krow !== 4'b1110) begin n_fail++; $display("FAIL rst_row got %b want 1110", krow); end
    n_tests++; if (keys !== 16'h0) begin n_fail++; $display("FAIL rst_keys got %h want 0", keys); end
    n_tests++; if (any_key !== 1'b0) begin n_fail++; $display("FAIL rst_any got %b want 0", any_key); end
    n_tests++; if (ev_vld !== 1'b0 || ev_code !== 4'd0 || ev_pr !== 1'b0) begin
      n_fail++; $display("FAIL rst_event got vld=%b code=%0d pr=%b want 0 0 0", ev_vld, ev_code, ev_pr);
    end
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      prev = krow; n = 0;
      while (krow == prev && n < 200) begin @(negedge clk); n++; end
      n_tests++;
      if (n != 22 || krow !== walk[t]) begin
        n_fail++; $display("FAIL idle_walk[%0d] got row=%b after %0d cycles want %b after 22", t, krow, n, walk[t]);
      end
    end
    n_tests++; if (keys !== 16'h0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL idle_quiet got keys=%h events=%0d want 0 0", keys, got_q.size());
    end
  endtask

  task automatic test_press_release();
    logic [15:0] want;
    for (int s = 1; s <= 8; s++) begin
      do_scan(16'h0020);
      want = (s >= DEB) ? 16'h0020 : 16'h0000;
      n_tests++;
      if (keys !== want || any_key !== (|want)) begin
        n_fail++; $display("FAIL press_scan%0d got keys=%h any=%b want %h", s, keys, any_key, want);
      end
    end
    n_tests++; if (got_q.size() != 1 || got_q[0] !== {4'd5, 1'b1}) begin
      n_fail++; $display("FAIL press_event got %0d events first=%h want 1 event %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 5'h0, {4'd5, 1'b1});
    end
    for (int s = 1; s <= 6; s++) begin
      do_scan(16'h0000);
      want = (s >= DEB) ? 16'h0000 : 16'h0020;
      n_tests++;
      if (keys !== want || any_key !== (|want)) begin
        n_fail++; $display("FAIL release_scan%0d got keys=%h any=%b want %h", s, keys, any_key, want);
      end
    end
    n_tests++; if (got_q.size() != 2 || got_q[1] !== {4'd5, 1'b0}) begin
      n_fail++; $display("FAIL release_event got %0d events last=%h want 2 events last %h", got_q.size(),
                         (got_q.size() > 1) ? got_q[1] : 5'h0, {4'd5, 1'b0});
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    for (int s = 0; s < 20; s++) begin
      do_scan((s % 2 == 0) ? 16'h0400 : 16'h0000);
      n_tests++;
      if (keys !== 16'h0) begin n_fail++; $display("FAIL bounce_scan%0d got keys=%h want 0", s, keys); end
    end
    n_tests++; if (got_q.size() != 0) begin
      n_fail++; $display("FAIL bounce_events got %0d want 0", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    rdy_mode = 2;
    for (int s = 0; s < DEB - 1; s++) do_scan(16'h0900);
    phys = 16'h0900;
    model_scan(16'h0900);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = ev_vld; end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_first_valid got none want valid within 400 cycles"); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (ev_vld !== 1'b1 || ev_code !== 4'd8 || ev_pr !== 1'b1 || krow !== 4'b1011) begin
        n_fail++; $display("FAIL bp_hold%0d got vld=%b code=%0d pr=%b row=%b want 1 8 1 1011",
                           i, ev_vld, ev_code, ev_pr, krow);
      end
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_boundary();
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== {4'd8, 1'b1} || got_q[1] !== {4'd11, 1'b1}) begin
      n_fail++; $display("FAIL bp_order got %0d events want (8,1) then (11,1)", got_q.size());
    end
    n_tests++; if (keys !== 16'h0900) begin n_fail++; $display("FAIL bp_keys got %h want 0900", keys); end
    got_q.delete(); exp_q.delete();
    for (int s = 0; s < DEB; s++) do_scan(16'h0000);
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== {4'd8, 1'b0} || got_q[1] !== {4'd11, 1'b0}) begin
      n_fail++; $display("FAIL bp_release got %0d events want (8,0) then (11,0)", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] pat;
    int hold;
    rdy_mode = 1;
    for (int p = 0; p < 10; p++) begin
      pat  = 16'($urandom) & 16'($urandom);
      hold = $urandom_range(1, 6);
      for (int s = 0; s < hold; s++) begin
        do_scan(pat);
        n_tests++;
        if (keys !== m_stable || any_key !== (|m_stable)) begin
          n_fail++; $display("FAIL rand_keys p%0d s%0d got %h any=%b want %h", p, s, keys, any_key, m_stable);
        end
      end
    end
    for (int s = 0; s < DEB; s++) do_scan(16'h0000);
    rdy_mode = 0;
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_ev_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_ev%0d got code=%0d pr=%b want code=%0d pr=%b",
                             i, got_q[i][4:1], got_q[i][0], exp_q[i][4:1], exp_q[i][0]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    int n;
    rdy_mode = 2;
    for (int s = 0; s < DEB - 1; s++) do_scan(16'h0001);
    phys = 16'h0001;
    model_scan(16'h0001);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = ev_vld; end
    n_tests++; if (!ok || ev_code !== 4'd0 || ev_pr !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending got vld=%b code=%0d pr=%b want 1 0 1", ev_vld, ev_code, ev_pr);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (ev_vld !== 1'b0 || keys !== 16'h0 || any_key !== 1'b0 || krow !== 4'b1110) begin
      n_fail++; $display("FAIL mid_async got vld=%b keys=%h any=%b row=%b want 0 0 0 1110",
                         ev_vld, keys, any_key, krow);
    end
    phys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    n = 0;
    while (krow == 4'b1110 && n < 200) begin @(negedge clk); n++; end
    n_tests++; if (n != 22 || krow !== 4'b1101) begin
      n_fail++; $display("FAIL mid_resume got row=%b after %0d cycles want 1101 after 22", krow, n);
    end
    n_tests++; if (got_q.size() != 0) begin
      n_fail++; $display("FAIL mid_discard got %0d accepted events want 0", got_q.size());
    end
    model_reset();
  endtask

  task automatic test_param_sweep();
    logic [1:0] prev;
    int n;
    s_phys = 6'b010000;
    @(negedge clk);
    s_rst = 1'b0;
    n_tests++; if (s_row !== 2'b10) begin n_fail++; $display("FAIL sweep_row0 got %b want 10", s_row); end
    for (int t = 0; t < 2; t++) begin
      prev = s_row; n = 0;
      while (s_row == prev && n < 100) begin @(negedge clk); n++; end
      n_tests++;
      if (n != 10 || s_row !== ((t == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL sweep_wrap%0d got row=%b after %0d cycles want %b after 10",
                           t, s_row, n, (t == 0) ? 2'b01 : 2'b10);
      end
    end
    n_tests++;
    if (s_got_q.size() != 1 || s_got_q[0] !== {3'd4, 1'b1} || s_keys !== 6'b010000 || s_any !== 1'b1) begin
      n_fail++; $display("FAIL sweep_press got %0d events keys=%b any=%b want 1 event (4,1) keys 010000",
                         s_got_q.size(), s_keys, s_any);
    end
    s_phys = '0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (s_got_q.size() != 2 || s_got_q[1] !== {3'd4, 1'b0} || s_keys !== 6'b0 || s_any !== 1'b0) begin
      n_fail++; $display("FAIL sweep_release got %0d events keys=%b any=%b want 2nd event (4,0) keys 0",
                         s_got_q.size(), s_keys, s_any);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_bounce();
    test_back_to_back();
    test_random();
    test_reset_mid_emit();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
